// File: rtl/ddr_reset_sequencer.sv
// Per-channel DDR reset sequencer: synchronizes an external reset, stretches it,
// then supervises calibration with an optional timeout and automatic retry.
module ddr_reset_sequencer #(
  parameter int CHANNELS      = 1,
  parameter int HOLD_CYCLES   = 16,
  parameter int CALIB_TIMEOUT = 1000000,
  parameter int AUTO_RETRY    = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] ddr_reset_in,
  input  logic [CHANNELS-1:0] calib_complete,
  output logic [CHANNELS-1:0] ddr_resetn_out,
  output logic [CHANNELS-1:0] ready,
  output logic [CHANNELS-1:0] fail,
  output logic                all_ready,
  output logic                zero
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = (CALIB_TIMEOUT > 0) ? $clog2(CALIB_TIMEOUT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'((CALIB_TIMEOUT > 0) ? CALIB_TIMEOUT - 1 : 0);
  localparam bit            TO_EN     = (CALIB_TIMEOUT > 0);
  localparam bit            RETRY     = (AUTO_RETRY != 0);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_WAIT_CAL,
    S_READY,
    S_FAIL
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]    sync;
    logic          sync_rst;
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic          rstn_q;
    logic          ready_q;
    logic          fail_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync <= 2'b11;
      else         sync <= {sync[0], ddr_reset_in[g]};
    end

    assign sync_rst = sync[1];

    // Output flags are updated on the same edge as the state they describe,
    // so they are registered yet never lag the state by a cycle.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state    <= S_RESET;
        hold_cnt <= '0;
        to_cnt   <= '0;
        rstn_q   <= 1'b0;
        ready_q  <= 1'b0;
        fail_q   <= 1'b0;
      end else if (sync_rst) begin
        state    <= S_RESET;
        hold_cnt <= '0;
        to_cnt   <= '0;
        rstn_q   <= 1'b0;
        ready_q  <= 1'b0;
      end else begin
        case (state)
          S_RESET: begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              state  <= S_WAIT_CAL;
              to_cnt <= '0;
              rstn_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          S_WAIT_CAL: begin
            if (calib_complete[g]) begin
              state   <= S_READY;
              ready_q <= 1'b1;
              fail_q  <= 1'b0;
            end else if (TO_EN && to_cnt == TO_LAST) begin
              state  <= S_FAIL;
              fail_q <= 1'b1;
              rstn_q <= 1'b0;
            end else if (to_cnt != '1) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_READY: begin
            if (!calib_complete[g]) begin
              state   <= S_WAIT_CAL;
              to_cnt  <= '0;
              ready_q <= 1'b0;
            end
          end
          S_FAIL: begin
            if (RETRY) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
          default: begin
            state   <= S_RESET;
            rstn_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        endcase
      end
    end

    assign ddr_resetn_out[g] = rstn_q;
    assign ready[g]          = ready_q;
    assign fail[g]           = fail_q;
  end

  assign all_ready = &ready;
  assign zero      = 1'b0;

endmodule

// File: tb/tb_ddr_reset_sequencer.sv
// Randomized bench for ddr_reset_sequencer: three parameter sets checked every
// cycle against a phase/elapsed-time reference model.
module tb_ddr_reset_sequencer;

  localparam int NI = 3;
  localparam int NC = 2;

  localparam int H0 = 4, T0 = 8, A0 = 0;
  localparam int H1 = 4, T1 = 8, A1 = 1;
  localparam int H2 = 3, T2 = 0, A2 = 0;

  int hold_p [NI] = '{H0, H1, H2};
  int to_p   [NI] = '{T0, T1, T2};
  int ar_p   [NI] = '{A0, A1, A2};

  logic          clk = 1'b0;
  logic          resetn;
  logic [NC-1:0] ddr_reset_in;
  logic [NC-1:0] calib  [NI];
  logic [NC-1:0] rstn_o [NI];
  logic [NC-1:0] rdy_o  [NI];
  logic [NC-1:0] fail_o [NI];
  logic          allr_o [NI];
  logic          zero_o [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr_reset_sequencer #(.CHANNELS(NC), .HOLD_CYCLES(H0), .CALIB_TIMEOUT(T0), .AUTO_RETRY(A0)) u_dut0 (
    .clk(clk), .resetn(resetn), .ddr_reset_in(ddr_reset_in), .calib_complete(calib[0]),
    .ddr_resetn_out(rstn_o[0]), .ready(rdy_o[0]), .fail(fail_o[0]), .all_ready(allr_o[0]), .zero(zero_o[0]));

  ddr_reset_sequencer #(.CHANNELS(NC), .HOLD_CYCLES(H1), .CALIB_TIMEOUT(T1), .AUTO_RETRY(A1)) u_dut1 (
    .clk(clk), .resetn(resetn), .ddr_reset_in(ddr_reset_in), .calib_complete(calib[1]),
    .ddr_resetn_out(rstn_o[1]), .ready(rdy_o[1]), .fail(fail_o[1]), .all_ready(allr_o[1]), .zero(zero_o[1]));

  ddr_reset_sequencer #(.CHANNELS(NC), .HOLD_CYCLES(H2), .CALIB_TIMEOUT(T2), .AUTO_RETRY(A2)) u_dut2 (
    .clk(clk), .resetn(resetn), .ddr_reset_in(ddr_reset_in), .calib_complete(calib[2]),
    .ddr_resetn_out(rstn_o[2]), .ready(rdy_o[2]), .fail(fail_o[2]), .all_ready(allr_o[2]), .zero(zero_o[2]));

  // Reference model: each channel is in a named phase and counts edges spent there.
  localparam int P_RST = 0, P_HOLD = 1, P_WAIT = 2, P_RDY = 3, P_FAIL = 4;
  int phase   [NI][NC];
  int elapsed [NI][NC];
  bit m_fail  [NI][NC];
  bit s1 [NC];
  bit s2 [NC];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      s1[c] = 1'b1;
      s2[c] = 1'b1;
      for (int i = 0; i < NI; i++) begin
        phase[i][c]   = P_RST;
        elapsed[i][c] = 0;
        m_fail[i][c]  = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int i, input int c);
    if (s2[c]) begin
      phase[i][c]   = P_RST;
      elapsed[i][c] = 0;
    end else begin
      case (phase[i][c])
        P_RST:  begin phase[i][c] = P_HOLD; elapsed[i][c] = 0; end
        P_HOLD: begin
          if (elapsed[i][c] == hold_p[i] - 1) begin phase[i][c] = P_WAIT; elapsed[i][c] = 0; end
          else elapsed[i][c]++;
        end
        P_WAIT: begin
          if (calib[i][c]) begin phase[i][c] = P_RDY; m_fail[i][c] = 1'b0; end
          else if (to_p[i] != 0 && elapsed[i][c] == to_p[i] - 1) begin
            phase[i][c] = P_FAIL;
            m_fail[i][c] = 1'b1;
          end else elapsed[i][c]++;
        end
        P_RDY:  if (!calib[i][c]) begin phase[i][c] = P_WAIT; elapsed[i][c] = 0; end
        default: if (ar_p[i] != 0) begin phase[i][c] = P_HOLD; elapsed[i][c] = 0; end
      endcase
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else begin
      for (int c = 0; c < NC; c++) begin
        for (int i = 0; i < NI; i++) model_step(i, c);
        s2[c] = s1[c];
        s1[c] = ddr_reset_in[c];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0] er, ey, ef;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NC; c++) begin
        er[c] = (phase[i][c] == P_WAIT) || (phase[i][c] == P_RDY);
        ey[c] = (phase[i][c] == P_RDY);
        ef[c] = m_fail[i][c];
      end
      check($sformatf("rstn_out%0d", i), 32'(rstn_o[i]), 32'(er));
      check($sformatf("ready%0d", i),    32'(rdy_o[i]),  32'(ey));
      check($sformatf("fail%0d", i),     32'(fail_o[i]), 32'(ef));
      check($sformatf("all_ready%0d", i), 32'(allr_o[i]), 32'(&ey));
      check($sformatf("zero%0d", i),     32'(zero_o[i]), 32'(0));
    end
  endtask

  task automatic check_async_zero();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async_rst%0d", i),
            32'({rstn_o[i], rdy_o[i], fail_o[i], allr_o[i]}), 32'(0));
    end
  endtask

  task automatic drive_calib();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (phase[i][c] == P_WAIT && to_p[i] != 0 && elapsed[i][c] == to_p[i] - 1)
          calib[i][c] = 1'($urandom_range(0, 1));
        else if (phase[i][c] == P_WAIT)
          calib[i][c] = ($urandom_range(0, 19) == 0);
        else if (phase[i][c] == P_RDY)
          calib[i][c] = ($urandom_range(0, 49) != 0);
        else
          calib[i][c] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    int rst_cnt;
    model_reset();
    resetn       = 1'b0;
    ddr_reset_in = '1;
    for (int i = 0; i < NI; i++) calib[i] = '0;
    repeat (3) @(negedge clk);
    check_async_zero();
    resetn = 1'b1;
    @(negedge clk);
    compare_all();

    // Reset-release latency: ddr_resetn_out rises HOLD_CYCLES+2 edges after E0.
    ddr_reset_in = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      compare_all();
      if (k == 5) check("lat_pre_h3",  32'(rstn_o[2][0]), 32'(0));
      if (k == 6) check("lat_rise_h3", 32'(rstn_o[2][0]), 32'(1));
      if (k == 6) check("lat_pre_h4",  32'(rstn_o[0][0]), 32'(0));
      if (k == 7) check("lat_rise_h4", 32'(rstn_o[0][0]), 32'(1));
    end

    rst_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      compare_all();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) resetn = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        resetn  = 1'b0;
        rst_cnt = $urandom_range(1, 3);
        #1;
        check_async_zero();
      end
      for (int c = 0; c < NC; c++) begin
        if (ddr_reset_in[c]) ddr_reset_in[c] = ($urandom_range(0, 3) != 0);
        else                 ddr_reset_in[c] = ($urandom_range(0, 149) == 0);
      end
      drive_calib();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
